// File: rtl/kf_sweep_ctrl.sv
// Exhaustive 4-input function tester: walks {A,B,C,D} through 0..15, lets each
// vector settle, samples Y and compares it against a latched golden truth table.
module kf_sweep_ctrl #(
  parameter int unsigned SETTLE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] expected,
  input  logic        Y,
  output logic        A,
  output logic        B,
  output logic        C,
  output logic        D,
  output logic        busy,
  output logic        done,
  output logic [15:0] truth_table,
  output logic [4:0]  mismatch_count,
  output logic [3:0]  first_fail_idx,
  output logic        pass
);

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [3:0]  settle_q, settle_d;
  logic [15:0] exp_q, exp_d;
  logic [15:0] tt_q, tt_d;
  logic [4:0]  mm_q, mm_d;
  logic [3:0]  ffi_q, ffi_d;
  logic        pass_q, pass_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      settle_q <= '0;
      exp_q    <= '0;
      tt_q     <= '0;
      mm_q     <= '0;
      ffi_q    <= '0;
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      settle_q <= settle_d;
      exp_q    <= exp_d;
      tt_q     <= tt_d;
      mm_q     <= mm_d;
      ffi_q    <= ffi_d;
      pass_q   <= pass_d;
    end
  end

  // abort beats start in IDLE and preempts both active states
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!abort && start) state_d = DRIVE;
      DRIVE:   if (abort) state_d = IDLE;
               else if (settle_q == SETTLE_LAST) state_d = SAMPLE;
      SAMPLE:  if (abort) state_d = IDLE;
               else if (idx_q == 4'd15) state_d = DONE;
               else state_d = DRIVE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A SAMPLE cycle captures its bit even when abort is coincident with it
  always_comb begin
    idx_d    = idx_q;
    settle_d = settle_q;
    exp_d    = exp_q;
    tt_d     = tt_q;
    mm_d     = mm_q;
    ffi_d    = ffi_q;
    pass_d   = pass_q;
    case (state_q)
      IDLE: begin
        if (!abort && start) begin
          idx_d    = '0;
          settle_d = '0;
          exp_d    = expected;
          tt_d     = '0;
          mm_d     = '0;
          ffi_d    = '0;
          pass_d   = 1'b0;
        end
      end
      DRIVE: settle_d = settle_q + 4'd1;
      SAMPLE: begin
        tt_d[idx_q] = Y;
        if (Y != exp_q[idx_q]) begin
          mm_d = mm_q + 5'd1;
          if (mm_q == 5'd0) ffi_d = idx_q;
        end
        if (!abort && idx_q != 4'd15) begin
          idx_d    = idx_q + 4'd1;
          settle_d = '0;
        end
      end
      DONE: pass_d = (mm_q == 5'd0);
      default: ;
    endcase
  end

  always_comb begin
    busy         = (state_q == DRIVE) || (state_q == SAMPLE);
    done         = (state_q == DONE);
    {A, B, C, D} = busy ? idx_q : 4'd0;
  end

  assign truth_table    = tt_q;
  assign mismatch_count = mm_q;
  assign first_fail_idx = ffi_q;
  assign pass           = pass_q;

endmodule

// File: tb/tb_kf_sweep_ctrl.sv
// Bench for kf_sweep_ctrl: a per-cycle scoreboard of {ABCD,busy,done} plus
// scenario tasks that check the final result registers against a bench model.
module tb_kf_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, abort;
  logic [15:0] expected;
  logic        Y, A, B, C, D, busy, done;
  logic [15:0] truth_table;
  logic [4:0]  mismatch_count;
  logic [3:0]  first_fail_idx;
  logic        pass;
  logic        stub_xor;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0] abcd;
    logic       busy;
    logic       done;
  } sb_t;

  sb_t sb[$];

  kf_sweep_ctrl #(.SETTLE(4)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .expected(expected),
    .Y(Y), .A(A), .B(B), .C(C), .D(D), .busy(busy), .done(done),
    .truth_table(truth_table), .mismatch_count(mismatch_count),
    .first_fail_idx(first_fail_idx), .pass(pass)
  );

  always #5 clk = ~clk;

  // Function under test: odd parity of the vector, or stuck at 0
  assign Y = stub_xor ? (A ^ B ^ C ^ D) : 1'b0;

  // Scoreboard consumer: one entry per cycle after the start edge
  always begin
    sb_t item;
    @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      item = sb.pop_front();
      checks++;
      if ({A, B, C, D} !== item.abcd || busy !== item.busy || done !== item.done) begin
        errors++;
        $display("[TB] FAIL cycle_trace: abcd=%0d busy=%b done=%b, required abcd=%0d busy=%b done=%b",
                 {A, B, C, D}, busy, done, item.abcd, item.busy, item.done);
      end
    end
  end

  function automatic logic [15:0] model_tt(input bit xor_mode);
    logic [15:0] tt;
    logic [3:0]  v;
    tt = '0;
    for (int i = 0; i < 16; i++) begin
      v = 4'(i);
      tt[i] = xor_mode ? ^v : 1'b0;
    end
    return tt;
  endfunction

  function automatic logic [4:0] model_mm(input logic [15:0] diff);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < 16; i++) n = n + 5'(diff[i]);
    return n;
  endfunction

  function automatic logic [3:0] model_ffi(input logic [15:0] diff);
    for (int i = 15; i >= 0; i--) if (diff[i]) model_ffi = 4'(i);
    if (diff == 16'h0) model_ffi = 4'd0;
  endfunction

  // Sweep cycles first..last: each index occupies 5 cycles, done follows cycle 80
  task automatic push_sweep(input int first, input int last);
    sb_t e;
    for (int c = first; c <= last; c++) begin
      if (c <= 80) begin
        e.abcd = 4'((c - 1) / 5);
        e.busy = 1'b1;
        e.done = 1'b0;
      end else begin
        e.abcd = 4'd0;
        e.busy = 1'b0;
        e.done = (c == 81);
      end
      sb.push_back(e);
    end
  endtask

  task automatic push_idle(input int n);
    sb_t e;
    e.abcd = 4'd0;
    e.busy = 1'b0;
    e.done = 1'b0;
    for (int i = 0; i < n; i++) sb.push_back(e);
  endtask

  task automatic wait_drain(output bit ok);
    for (int n = 0; n < 300 && sb.size() != 0; n++) @(negedge clk);
    ok = (sb.size() == 0);
    if (!ok) sb.delete();
  endtask

  task automatic do_sweep(input logic [15:0] exp_tt, input bit xor_mode, output bit ok);
    @(negedge clk);
    expected = exp_tt;
    stub_xor = xor_mode;
    start    = 1'b1;
    push_sweep(1, 82);
    @(negedge clk);
    start = 1'b0;
    wait_drain(ok);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; abort = 1'b0; expected = 16'h6996; stub_xor = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({A, B, C, D, busy, done, pass} !== 7'b0 || truth_table !== 16'h0 ||
        mismatch_count !== 5'd0 || first_fail_idx !== 4'd0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: abcd=%0d busy=%b done=%b pass=%b tt=%h mm=%0d ffi=%0d, required all 0",
               {A, B, C, D}, busy, done, pass, truth_table, mismatch_count, first_fail_idx);
    end
    rst = 1'b0; start = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || {A, B, C, D} !== 4'd0) begin
        errors++;
        $display("[TB] FAIL reset_no_sweep: busy=%b abcd=%0d, required busy=0 abcd=0", busy, {A, B, C, D});
      end
    end
  endtask

  task automatic check_results(input string name, input logic [15:0] exp_tt, input bit xor_mode);
    logic [15:0] tt;
    tt = model_tt(xor_mode);
    checks++;
    if (truth_table !== tt) begin
      errors++;
      $display("[TB] FAIL %s_tt: got %h, required %h", name, truth_table, tt);
    end
    checks++;
    if (mismatch_count !== model_mm(tt ^ exp_tt)) begin
      errors++;
      $display("[TB] FAIL %s_mm: got %0d, required %0d", name, mismatch_count, model_mm(tt ^ exp_tt));
    end
    checks++;
    if (first_fail_idx !== model_ffi(tt ^ exp_tt)) begin
      errors++;
      $display("[TB] FAIL %s_ffi: got %0d, required %0d", name, first_fail_idx, model_ffi(tt ^ exp_tt));
    end
    checks++;
    if (pass !== ((tt ^ exp_tt) == 16'h0)) begin
      errors++;
      $display("[TB] FAIL %s_pass: got %b, required %b", name, pass, ((tt ^ exp_tt) == 16'h0));
    end
  endtask

  task automatic test_clean_sweep();
    bit ok;
    do_sweep(16'h6996, 1'b1, ok);
    checks++;
    if (!ok) begin errors++; $display("[TB] FAIL clean_timeout: trace incomplete, required drained"); end
    check_results("clean", 16'h6996, 1'b1);
  endtask

  task automatic test_single_mismatch();
    bit ok;
    do_sweep(16'h6997, 1'b1, ok);
    checks++;
    if (!ok) begin errors++; $display("[TB] FAIL single_timeout: trace incomplete, required drained"); end
    check_results("single", 16'h6997, 1'b1);
  endtask

  task automatic test_full_failure();
    bit ok;
    do_sweep(16'hFFFF, 1'b0, ok);
    checks++;
    if (!ok) begin errors++; $display("[TB] FAIL full_timeout: trace incomplete, required drained"); end
    check_results("full", 16'hFFFF, 1'b0);
  endtask

  task automatic test_restart_abort();
    bit ok;
    logic [15:0] tt;
    @(negedge clk);
    expected = 16'h6994; stub_xor = 1'b1; start = 1'b1;
    push_sweep(1, 30);
    push_idle(4);
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || {A, B, C, D} !== 4'd0) begin
      errors++;
      $display("[TB] FAIL abort_idle: busy=%b abcd=%0d, required busy=0 abcd=0", busy, {A, B, C, D});
    end
    wait_drain(ok);
    checks++;
    if (!ok) begin errors++; $display("[TB] FAIL abort_timeout: trace incomplete, required drained"); end
    tt = model_tt(1'b1) & 16'h003F;
    checks++;
    if (truth_table !== tt) begin
      errors++;
      $display("[TB] FAIL abort_tt: got %h, required %h", truth_table, tt);
    end
    checks++;
    if (mismatch_count !== 5'd1 || first_fail_idx !== 4'd1 || pass !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abort_results: mm=%0d ffi=%0d pass=%b, required mm=1 ffi=1 pass=0",
               mismatch_count, first_fail_idx, pass);
    end
  endtask

  task automatic test_reset_mid_sweep();
    bit ok;
    @(negedge clk);
    expected = 16'h0000; stub_xor = 1'b1; start = 1'b1;
    push_sweep(1, 40);
    push_idle(1);
    @(negedge clk);
    start = 1'b0;
    repeat (39) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || truth_table !== 16'h0 || mismatch_count !== 5'd0 ||
        first_fail_idx !== 4'd0 || pass !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midreset_clear: busy=%b tt=%h mm=%0d ffi=%0d pass=%b, required all 0",
               busy, truth_table, mismatch_count, first_fail_idx, pass);
    end
    wait_drain(ok);
    checks++;
    if (!ok) begin errors++; $display("[TB] FAIL midreset_timeout: trace incomplete, required drained"); end
    do_sweep(16'h6996, 1'b1, ok);
    checks++;
    if (!ok) begin errors++; $display("[TB] FAIL resweep_timeout: trace incomplete, required drained"); end
    check_results("resweep", 16'h6996, 1'b1);
  endtask

  initial begin
    test_reset();
    test_clean_sweep();
    test_single_mismatch();
    test_full_failure();
    test_restart_abort();
    test_reset_mid_sweep();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
